// File: rtl/fpu_compare_pipe.sv
// fpu_compare_pipe: pipelined IEEE-754 compare/min/max unit with valid/ready handshake
module fpu_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               opcode,
  input  logic [EXP_W+MAN_W:0]     op_a,
  input  logic [EXP_W+MAN_W:0]     op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              cmp_result,
  output logic [EXP_W+MAN_W:0]     minmax_result,
  output logic                     flag_nv
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int BW = 8 + 2 * W + 7;
  localparam int RW = W + 2;
  localparam int D  = (LAT > 1) ? LAT - 1 : 1;
  localparam logic [W-1:0] C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic          w_stall;
  logic [7:0]    w_op;
  logic          w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_zz, w_mag_lt, w_mag_eq;
  logic [BW-1:0] w_d, w_x;
  logic          w_xv;
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_op     = opcode & (~opcode + 8'd1);
  assign w_a_nan  = (&op_a[W-2:MAN_W]) & (|op_a[MAN_W-1:0]);
  assign w_b_nan  = (&op_b[W-2:MAN_W]) & (|op_b[MAN_W-1:0]);
  assign w_a_snan = w_a_nan & ~op_a[MAN_W-1];
  assign w_b_snan = w_b_nan & ~op_b[MAN_W-1];
  assign w_zz     = ~|{op_a[W-2:0], op_b[W-2:0]};
  assign w_mag_lt = op_a[W-2:0] < op_b[W-2:0];
  assign w_mag_eq = op_a[W-2:0] == op_b[W-2:0];
  assign w_d = {w_op, op_a, op_b, w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_zz, w_mag_lt, w_mag_eq};
  // With a single stage the decode feeds the select directly; otherwise it is registered first
  if (LAT == 1) begin : g_comb
    assign w_x  = w_d;
    assign w_xv = in_valid;
  end else begin : g_s1
    logic [BW-1:0] r_s1;
    logic          r_s1_v;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s1   <= '0;
        r_s1_v <= 1'b0;
      end else if (!w_stall) begin
        r_s1   <= w_d;
        r_s1_v <= in_valid;
      end
    end
    assign w_x  = r_s1;
    assign w_xv = r_s1_v;
  end
  logic [7:0]   w_xop;
  logic [W-1:0] w_xa, w_xb;
  logic         w_xan, w_xbn, w_xas, w_xbs, w_xzz, w_xlt, w_xeq;
  logic         w_nan, w_snan, w_eq, w_lt, w_min_a, w_max_a, w_cmp, w_nv;
  logic [W-1:0] w_mm;
  assign {w_xop, w_xa, w_xb, w_xan, w_xbn, w_xas, w_xbs, w_xzz, w_xlt, w_xeq} = w_x;
  assign w_nan  = w_xan | w_xbn;
  assign w_snan = w_xas | w_xbs;
  assign w_eq   = w_xzz | (w_xeq & (w_xa[W-1] == w_xb[W-1]));
  assign w_lt   = ~w_xzz & ((w_xa[W-1] != w_xb[W-1]) ? w_xa[W-1] :
                            (w_xa[W-1] ? (~w_xlt & ~w_xeq) : w_xlt));
  // Signed zeros: min prefers the negative one, max the positive one
  assign w_min_a = w_xzz ? w_xa[W-1] : (w_lt | w_eq);
  assign w_max_a = w_xzz ? ~w_xa[W-1] : ~w_lt;
  always_comb begin
    w_cmp = 1'b0;
    w_mm  = '0;
    w_nv  = 1'b0;
    if (w_xop[0]) begin
      w_cmp = ~w_nan & w_eq;
      w_nv  = w_snan;
    end else if (w_xop[1]) begin
      w_cmp = w_nan | ~w_eq;
      w_nv  = w_snan;
    end else if (w_xop[2]) begin
      w_cmp = ~w_nan & w_lt;
      w_nv  = w_nan;
    end else if (w_xop[3]) begin
      w_cmp = ~w_nan & (w_lt | w_eq);
      w_nv  = w_nan;
    end else if (w_xop[4]) begin
      w_cmp = ~w_nan & ~w_lt & ~w_eq;
      w_nv  = w_nan;
    end else if (w_xop[5]) begin
      w_cmp = ~w_nan & ~w_lt;
      w_nv  = w_nan;
    end else if (w_xop[6] | w_xop[7]) begin
      w_nv = w_snan;
      w_mm = (w_xan & w_xbn) ? C_QNAN : w_xan ? w_xb : w_xbn ? w_xa :
             ((w_xop[6] ? w_min_a : w_max_a) ? w_xa : w_xb);
    end
  end
  logic [RW-1:0] w_res;
  logic [RW-1:0] r_res [D];
  logic [D-1:0]  r_v;
  logic          w_oc;
  assign w_res = {w_cmp, w_mm, w_nv};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      for (int i = 0; i < D; i++) r_res[i] <= '0;
    end else if (!w_stall) begin
      r_v[0]   <= w_xv;
      r_res[0] <= w_res;
      for (int i = 1; i < D; i++) begin
        r_v[i]   <= r_v[i-1];
        r_res[i] <= r_res[i-1];
      end
    end
  end
  assign out_valid = r_v[D-1];
  assign {w_oc, minmax_result, flag_nv} = r_res[D-1];
  assign cmp_result = {31'd0, w_oc};
endmodule

// File: tb/tb_fpu_compare_pipe.sv
// tb_fpu_compare_pipe: directed IEEE cases plus randomized scoreboard run against a value-level model
module tb_fpu_compare_pipe;
  localparam int LAT = 2;
  localparam int W   = 32;
  logic          clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, flag_nv;
  logic [7:0]    opcode = '0;
  logic [W-1:0]  op_a = '0, op_b = '0, minmax_result;
  logic [31:0]   cmp_result;
  int            n_chk = 0, n_fail = 0;
  typedef struct packed {logic [31:0] c; logic [W-1:0] m; logic nv;} res_t;
  res_t          q[$];
  logic          hold_pending = 1'b0;
  logic [65:0]   held;
  logic [31:0]   pool [12] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                               32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                               32'hFFC00001, 32'h00000001, 32'h807FFFFF, 32'h40000000};
  always #5 clk = ~clk;
  fpu_compare_pipe #(.EXP_W(8), .MAN_W(23), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .cmp_result(cmp_result), .minmax_result(minmax_result), .flag_nv(flag_nv)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Values ordered as signed-magnitude integers; both zeros map to key 0
  function automatic res_t model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    res_t   r;
    bit     an, bn, as, bs, lt, eq;
    longint ka, kb;
    int     k;
    r  = '0;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    as = an && !a[22];
    bs = bn && !b[22];
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    lt = ka < kb;
    eq = ka == kb;
    k  = -1;
    for (int i = 7; i >= 0; i--) if (op[i]) k = i;
    case (k)
      0: begin r.c = {31'd0, !an && !bn && eq}; r.nv = as || bs; end
      1: begin r.c = {31'd0, an || bn || !eq};  r.nv = as || bs; end
      2: begin r.c = {31'd0, !an && !bn && lt};        r.nv = an || bn; end
      3: begin r.c = {31'd0, !an && !bn && (lt || eq)}; r.nv = an || bn; end
      4: begin r.c = {31'd0, !an && !bn && kb < ka};   r.nv = an || bn; end
      5: begin r.c = {31'd0, !an && !bn && kb <= ka};  r.nv = an || bn; end
      6, 7: begin
        r.nv = as || bs;
        if (an && bn) r.m = 32'h7FC00000;
        else if (an) r.m = b;
        else if (bn) r.m = a;
        else if (eq) r.m = (ka == 0) ? (((k == 6) == a[31]) ? a : b) : a;
        else r.m = ((k == 6) == lt) ? a : b;
      end
      default: ;
    endcase
    return r;
  endfunction
  function automatic logic [31:0] pick();
    return ($urandom % 2) ? pool[$urandom % 12] : $urandom;
  endfunction
  task automatic step(input bit v, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit ordy, output bit acc);
    res_t e;
    @(negedge clk);
    in_valid = v; opcode = op; op_a = a; op_b = b; out_ready = ordy;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (hold_pending) check("hold", {out_valid, cmp_result, minmax_result, flag_nv}, held);
    hold_pending = out_valid && !out_ready;
    held = {out_valid, cmp_result, minmax_result, flag_nv};
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious", out_valid, 0);
      else begin
        e = q.pop_front();
        check("cmp", cmp_result, e.c);
        check("mm", minmax_result, e.m);
        check("nv", flag_nv, e.nv);
      end
    end
    acc = v && in_ready;
    if (acc) q.push_back(model(op, a, b));
  endtask
  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 8'h00, 0, 0, 1, acc);
    check("drain", q.size(), 0);
    @(negedge clk);
    in_valid = 0;
    hold_pending = 0;
  endtask
  task automatic run1(input string tag, input logic [7:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] ec, input logic [31:0] em, input bit env);
    int n;
    @(negedge clk);
    in_valid = 1; opcode = op; op_a = a; op_b = b; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_cmp"}, cmp_result, ec);
    check({tag, "_mm"}, minmax_result, em);
    check({tag, "_nv"}, flag_nv, env);
    hold_pending = 0;
  endtask
  initial begin
    bit acc;
    int cyc;
    logic [31:0] a, b;
    logic [7:0] op;
    repeat (2) @(negedge clk);
    check("rst_ov", out_valid, 0);
    check("rst_cmp", cmp_result, 0);
    check("rst_mm", minmax_result, 0);
    check("rst_nv", flag_nv, 0);
    check("rst_ir", in_ready, 1);
    rst = 0;
    run1("flt", 8'h04, 32'hBF800000, 32'h3F800000, 1, 0, 0);
    run1("feq_z", 8'h01, 32'h80000000, 32'h00000000, 1, 0, 0);
    run1("fmin_z", 8'h40, 32'h80000000, 32'h00000000, 0, 32'h80000000, 0);
    run1("fmax_z", 8'h80, 32'h80000000, 32'h00000000, 0, 32'h00000000, 0);
    run1("fmin_zs", 8'h40, 32'h00000000, 32'h80000000, 0, 32'h80000000, 0);
    run1("fmax_zs", 8'h80, 32'h00000000, 32'h80000000, 0, 32'h00000000, 0);
    run1("fle_q", 8'h08, 32'h7FC00000, 32'h3F800000, 0, 0, 1);
    run1("feq_q", 8'h01, 32'h7FC00000, 32'h3F800000, 0, 0, 0);
    run1("fne_s", 8'h02, 32'h7F800001, 32'h3F800000, 1, 0, 1);
    run1("fmax_s", 8'h80, 32'h7F800001, 32'hC0000000, 0, 32'hC0000000, 1);
    run1("fmin_qq", 8'h40, 32'h7FC00000, 32'h7FC00000, 0, 32'h7FC00000, 0);
    run1("op0", 8'h00, 32'h3F800000, 32'h3F800000, 0, 0, 0);
    run1("multi", 8'hC4, 32'hBF800000, 32'h3F800000, 1, 0, 0);
    run1("fge_sub", 8'h20, 32'h00000002, 32'h00000001, 1, 0, 0);
    run1("fmax_eq", 8'h80, 32'h40000000, 32'h40000000, 0, 32'h40000000, 0);
    // Four back-to-back ops with a three-cycle output stall in the middle
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      a = pool[k + 1]; b = pool[k + 2];
      op = 8'h01 << (k * 2);
      acc = 0;
      for (int t = 0; t < 10 && !acc; t++) begin
        step(1, op, a, b, !(cyc >= 2 && cyc <= 4), acc);
        cyc++;
      end
      check("stream_acc", acc, 1);
    end
    drain();
    for (int i = 0; i < 400; i++) begin
      a = pick();
      b = ($urandom % 6 == 0) ? a : ($urandom % 6 == 0) ? (a ^ 32'h80000000) : pick();
      case ($urandom % 10)
        0: op = 8'h00;
        1: op = 8'($urandom);
        default: op = 8'h01 << ($urandom % 8);
      endcase
      step($urandom % 4 != 0, op, a, b, $urandom % 4 != 0, acc);
    end
    drain();
    step(1, 8'h04, 32'hBF800000, 32'h3F800000, 1, acc);
    step(1, 8'h01, 32'h3F800000, 32'h3F800000, 1, acc);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1;
    check("mid_rst_ov", out_valid, 0);
    check("mid_rst_cmp", cmp_result, 0);
    check("mid_rst_nv", flag_nv, 0);
    q.delete();
    hold_pending = 0;
    @(negedge clk);
    rst = 0;
    run1("post_rst", 8'h10, 32'h40000000, 32'h3F800000, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
